mem_writeback: RTL and testbench

//  Memory + writeback stage, the write end of the register file read by the decode stage.

---
 rtl/mem_writeback_pkg.sv | 45 ++++
 rtl/mem_writeback_load_extend.sv | 26 ++
 rtl/mem_writeback.sv | 160 ++++++++++++++++
 tb/tb_mem_writeback.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_writeback_pkg.sv
// Shared constants for the memory/writeback stage: width codes, writeback source
// encoding, FSM state constants and the WB pipeline register layout.
package mem_writeback_pkg;

    localparam logic [2:0] FNC_LB  = 3'b000;
    localparam logic [2:0] FNC_LH  = 3'b001;
    localparam logic [2:0] FNC_LW  = 3'b010;
    localparam logic [2:0] FNC_LBU = 3'b100;
    localparam logic [2:0] FNC_LHU = 3'b101;
    localparam logic [2:0] FNC_SB  = 3'b000;
    localparam logic [2:0] FNC_SH  = 3'b001;
    localparam logic [2:0] FNC_SW  = 3'b010;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_t;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    typedef struct packed {
        logic        reg_we;
        logic        mem_rr;
        logic        mem_we;
        logic        csr_write;
        wb_sel_t     sel;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] store_data;
    } wb_reg_t;

    // Byte lane actually used: halfwords drop a[0], words drop a[1:0].
    function automatic logic [1:0] lane_of(input logic [2:0] funct3, input logic [1:0] a);
        case (funct3[1:0])
            2'b00:   return a;
            2'b01:   return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_writeback_load_extend.sv
// Load data alignment: shifts the addressed lane down and sign/zero-extends it.
module mem_writeback_load_extend
    import mem_writeback_pkg::*;
(
    input  logic [31:0] dout,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    logic [31:0] shifted;

    assign shifted = dout >> {lane, 3'b000};

    always_comb begin
        value = shifted;
        case (funct3)
            FNC_LB:  value = {{24{shifted[7]}}, shifted[7:0]};
            FNC_LH:  value = {{16{shifted[15]}}, shifted[15:0]};
            FNC_LBU: value = {24'h0, shifted[7:0]};
            FNC_LHU: value = {16'h0, shifted[15:0]};
            default: value = shifted;
        endcase
    end

endmodule

// File: rtl/mem_writeback.sv
// Memory + writeback stage: issues data cache requests, holds the WB register
// through cache misses, commits to the register file and latches CSR writes.
module mem_writeback
    import mem_writeback_pkg::*;
#(
    parameter logic [31:0] RESET_TOHOST = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bubble,
    input  logic        ex_reg_we,
    input  logic        ex_mem_rr,
    input  logic        ex_mem_we,
    input  logic        ex_csr_write,
    input  logic        ex_link,
    input  logic [2:0]  ex_funct3,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_alu,
    input  logic [31:0] ex_pc4,
    input  logic [31:0] ex_store_data,
    output logic [31:0] dcache_addr,
    output logic        dcache_re,
    output logic [3:0]  dcache_we,
    output logic [31:0] dcache_din,
    input  logic [31:0] dcache_dout,
    input  logic        dcache_stall,
    output logic        stall_out,
    output logic        we,
    output logic [4:0]  wa,
    output logic [31:0] wd,
    output logic [31:0] csr_tohost,
    output logic [0:0]  dbg_state
);

    // Cache handshake: a request (re or any we bit) is presented in cycle N; in
    // cycle N+1 dcache_stall=0 means done (dout valid for loads), otherwise the
    // request is re-presented unchanged every WAIT cycle until stall drops.

    logic [0:0]  state;
    wb_reg_t     wb;
    wb_reg_t     ex_wb;
    logic        wb_mem;
    logic        miss_hold;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [2:0]  req_funct3;
    logic        req_rr;
    logic        req_wr;
    logic [1:0]  req_lane;
    logic [3:0]  req_mask;
    logic [31:0] load_value;

    assign wb_mem    = wb.mem_rr | wb.mem_we;
    assign miss_hold = (state == ST_RUN) && wb_mem && dcache_stall;
    assign stall_out = (state == ST_WAIT) || miss_hold;
    assign dbg_state = state;

    always_comb begin
        ex_wb            = '0;
        ex_wb.reg_we     = ex_reg_we;
        ex_wb.mem_rr     = ex_mem_rr;
        ex_wb.mem_we     = ex_mem_we;
        ex_wb.csr_write  = ex_csr_write;
        ex_wb.sel        = ex_link ? WB_PC4 : (ex_mem_rr ? WB_MEM : WB_ALU);
        ex_wb.funct3     = ex_funct3;
        ex_wb.rd         = ex_rd;
        ex_wb.alu        = ex_alu;
        ex_wb.pc4        = ex_pc4;
        ex_wb.store_data = ex_store_data;
    end

    // WAIT replays the held WB access; RUN issues from EX unless a miss is being taken.
    always_comb begin
        req_addr   = ex_alu;
        req_data   = ex_store_data;
        req_funct3 = ex_funct3;
        req_rr     = ex_mem_rr & ~ex_mem_we & ~bubble & ~miss_hold;
        req_wr     = ex_mem_we & ~bubble & ~miss_hold;
        if (state == ST_WAIT) begin
            req_addr   = wb.alu;
            req_data   = wb.store_data;
            req_funct3 = wb.funct3;
            req_rr     = wb.mem_rr & ~wb.mem_we;
            req_wr     = wb.mem_we;
        end
        if (rst) begin
            req_rr = 1'b0;
            req_wr = 1'b0;
        end
    end

    assign req_lane = lane_of(req_funct3, req_addr[1:0]);

    always_comb begin
        case (req_funct3[1:0])
            2'b00:   req_mask = 4'b0001 << req_lane;
            2'b01:   req_mask = 4'b0011 << req_lane;
            default: req_mask = 4'b1111;
        endcase
    end

    assign dcache_addr = {req_addr[31:2], 2'b00};
    assign dcache_re   = req_rr;
    assign dcache_we   = req_wr ? req_mask : 4'b0000;
    assign dcache_din  = req_data << {req_lane, 3'b000};

    mem_writeback_load_extend u_load_extend (
        .dout   (dcache_dout),
        .lane   (lane_of(wb.funct3, wb.alu[1:0])),
        .funct3 (wb.funct3),
        .value  (load_value)
    );

    assign we = wb.reg_we && (wb.rd != 5'd0) && !(wb.mem_rr && dcache_stall);
    assign wa = wb.rd;

    always_comb begin
        case (wb.sel)
            WB_PC4:  wd = wb.pc4;
            WB_MEM:  wd = load_value;
            default: wd = wb.alu;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RUN;
            wb         <= '0;
            csr_tohost <= RESET_TOHOST;
        end else begin
            if (state == ST_RUN && wb.csr_write) begin
                csr_tohost <= wb.alu;
            end
            case (state)
                ST_RUN: begin
                    if (miss_hold) begin
                        state <= ST_WAIT;
                    end else if (bubble) begin
                        wb.reg_we    <= 1'b0;
                        wb.mem_rr    <= 1'b0;
                        wb.mem_we    <= 1'b0;
                        wb.csr_write <= 1'b0;
                    end else begin
                        wb <= ex_wb;
                    end
                end
                default: begin
                    if (!dcache_stall) begin
                        state        <= ST_RUN;
                        wb.reg_we    <= 1'b0;
                        wb.mem_rr    <= 1'b0;
                        wb.mem_we    <= 1'b0;
                        wb.csr_write <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_writeback.sv
// Randomized bench for mem_writeback: a cache responder with a word memory, a
// reference model computing commits/requests from the instruction stream, and monitors.
module tb_mem_writeback;

    localparam logic [31:0] RST_TOHOST = 32'h0000_00A5;

    logic        clk;
    logic        rst;
    logic        bubble;
    logic        ex_reg_we, ex_mem_rr, ex_mem_we, ex_csr_write, ex_link;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic [31:0] ex_alu, ex_pc4, ex_store_data;
    logic [31:0] dcache_addr, dcache_din, dcache_dout;
    logic        dcache_re, dcache_stall;
    logic [3:0]  dcache_we;
    logic        stall_out, we;
    logic [4:0]  wa;
    logic [31:0] wd, csr_tohost;
    logic [0:0]  dbg_state;

    typedef struct packed {
        logic [31:0] addr;
        logic        re;
        logic [3:0]  mask;
        logic [31:0] din;
    } req_t;

    typedef struct packed {
        logic        bub;
        logic        reg_we;
        logic        rr;
        logic        mw;
        logic        csr;
        logic        link;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] sd;
    } op_t;

    int          errors = 0;
    int          checks = 0;
    logic [36:0] exp_q[$];
    req_t        req_q[$];
    logic [31:0] csr_q[$];
    logic [31:0] ref_mem[16];
    logic [31:0] cache_mem[16];
    logic [31:0] last_csr_model;
    int          force_k = -1;
    logic        pending = 1'b0;

    mem_writeback #(.RESET_TOHOST(RST_TOHOST)) dut (
        .clk(clk), .rst(rst), .bubble(bubble),
        .ex_reg_we(ex_reg_we), .ex_mem_rr(ex_mem_rr), .ex_mem_we(ex_mem_we),
        .ex_csr_write(ex_csr_write), .ex_link(ex_link), .ex_funct3(ex_funct3),
        .ex_rd(ex_rd), .ex_alu(ex_alu), .ex_pc4(ex_pc4), .ex_store_data(ex_store_data),
        .dcache_addr(dcache_addr), .dcache_re(dcache_re), .dcache_we(dcache_we),
        .dcache_din(dcache_din), .dcache_dout(dcache_dout), .dcache_stall(dcache_stall),
        .stall_out(stall_out), .we(we), .wa(wa), .wd(wd),
        .csr_tohost(csr_tohost), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int access_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int access_lane(input logic [2:0] f3, input logic [31:0] a);
        int sz = access_size(f3);
        if (sz == 1) return int'(a % 4);
        if (sz == 2) return 2 * int'((a % 4) / 2);
        return 0;
    endfunction

    function automatic logic [31:0] load_model(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [31:0] a);
        logic [31:0] sh;
        int v;
        sh = word >> (8 * access_lane(f3, a));
        case (f3)
            3'd0: begin v = int'(sh % 256);   if (v >= 128)   v -= 256;   return v; end
            3'd1: begin v = int'(sh % 65536); if (v >= 32768) v -= 65536; return v; end
            3'd4: return sh % 256;
            3'd5: return sh % 65536;
            default: return word;
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input op_t op);
        bubble        = op.bub;
        ex_reg_we     = op.reg_we;
        ex_mem_rr     = op.rr;
        ex_mem_we     = op.mw;
        ex_csr_write  = op.csr;
        ex_link       = op.link;
        ex_funct3     = op.f3;
        ex_rd         = op.rd;
        ex_alu        = op.alu;
        ex_pc4        = op.pc4;
        ex_store_data = op.sd;
    endtask

    task automatic issue(input op_t op, input bit expect_commit);
        int   idx, lane, sz;
        req_t r;
        logic s;
        bit   done;
        drive(op);
        if (!op.bub) begin
            idx  = int'((op.alu / 4) % 16);
            sz   = access_size(op.f3);
            lane = access_lane(op.f3, op.alu);
            if (op.rr || op.mw) begin
                r.addr = op.alu - (op.alu % 4);
                r.re   = !op.mw;
                r.mask = op.mw ? 4'(((1 << sz) - 1) << lane) : 4'b0000;
                r.din  = op.sd << (8 * lane);
                req_q.push_back(r);
            end
            if (op.reg_we && op.rd != 5'd0 && expect_commit) begin
                if (op.link)    exp_q.push_back({op.rd, op.pc4});
                else if (op.rr) exp_q.push_back({op.rd, load_model(ref_mem[idx], op.f3, op.alu)});
                else            exp_q.push_back({op.rd, op.alu});
            end
            if (op.mw) begin
                for (int i = 0; i < sz; i++) ref_mem[idx][8*(lane+i) +: 8] = op.sd[8*i +: 8];
            end
            if (op.csr) begin
                csr_q.push_back(op.alu);
                last_csr_model = op.alu;
            end
        end
        done = 1'b0;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            s = stall_out;
            @(posedge clk);
            #1;
            if (!s) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: stall_out stuck at 1 expected release within 20 cycles");
        end
    endtask

    task automatic nop();
        op_t op = '0;
        op.bub = 1'b1;
        issue(op, 1'b1);
    endtask

    task automatic rand_op();
        op_t op = '0;
        int  k  = $urandom_range(0, 9);
        logic [2:0] ld_codes[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        op.alu = $urandom;
        op.pc4 = $urandom;
        op.sd  = $urandom;
        op.f3  = 3'($urandom_range(0, 7));
        op.rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        if (k <= 2) begin
            op.reg_we = 1'b1;
        end else if (k <= 4) begin
            op.reg_we = 1'b1;
            op.rr     = 1'b1;
            op.f3     = ld_codes[$urandom_range(0, 4)];
            op.alu    = 32'h1000 + $urandom_range(0, 63);
        end else if (k <= 6) begin
            op.mw  = 1'b1;
            op.f3  = 3'($urandom_range(0, 2));
            op.alu = 32'h1000 + $urandom_range(0, 63);
        end else if (k == 7) begin
            op.csr = 1'b1;
            if (op.alu == last_csr_model) op.alu = op.alu + 1;
        end else if (k == 8) begin
            op.reg_we = 1'b1;
            op.link   = 1'b1;
        end else begin
            op.bub    = 1'b1;
            op.reg_we = 1'b1;
        end
        issue(op, 1'b1);
    endtask

    task automatic drain();
        for (int t = 0; t < 40; t++) begin
            if (exp_q.size() == 0 && req_q.size() == 0 && csr_q.size() == 0 && !pending) break;
            nop();
        end
        nop();
    endtask

    // ---------------- cache responder ----------------
    initial begin
        int   p_k, p_miss, p_cnt;
        bit   p_first;
        req_t p_req;
        dcache_stall = 1'b0;
        dcache_dout  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pending      = 1'b0;
                dcache_stall = 1'b0;
                continue;
            end
            if (pending) begin
                if (stall_out) p_cnt++;
                if (!p_first) begin
                    check("replay_addr", dcache_addr, p_req.addr);
                    check("replay_re", dcache_re, p_req.re);
                    check("replay_we", dcache_we, p_req.mask);
                    if (p_req.mask != 4'b0000) check("replay_din", dcache_din, p_req.din);
                end else if (dcache_stall) begin
                    check("miss_req_deassert", {dcache_re, dcache_we}, 5'b0);
                end
                if (!dcache_stall) begin
                    for (int i = 0; i < 4; i++)
                        if (p_req.mask[i]) cache_mem[p_req.addr[5:2]][8*i +: 8] = p_req.din[8*i +: 8];
                    check("stall_out_cycles", p_cnt, (p_miss > 0) ? p_miss + 1 : 0);
                    pending = 1'b0;
                end
                p_first = 1'b0;
            end
            if (!stall_out && (dcache_re || dcache_we != 4'b0000)) begin
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_request: got addr %h re %b we %b expected none",
                             dcache_addr, dcache_re, dcache_we);
                    p_req = '{addr: dcache_addr, re: dcache_re, mask: dcache_we, din: dcache_din};
                end else begin
                    p_req = req_q.pop_front();
                    check("req_addr", dcache_addr, p_req.addr);
                    check("req_re", dcache_re, p_req.re);
                    check("req_we", dcache_we, p_req.mask);
                    if (p_req.mask != 4'b0000) check("req_din", dcache_din, p_req.din);
                end
                if (force_k >= 0) begin
                    p_miss  = force_k;
                    force_k = -1;
                end else begin
                    p_miss = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                end
                p_k     = p_miss;
                p_cnt   = 0;
                p_first = 1'b1;
                pending = 1'b1;
            end
            @(posedge clk);
            #1;
            if (pending) begin
                dcache_stall = (p_k > 0);
                if (p_k > 0) begin
                    p_k--;
                    dcache_dout = $urandom;
                end else begin
                    dcache_dout = cache_mem[p_req.addr[5:2]];
                end
            end else begin
                dcache_stall = ($urandom_range(0, 3) == 0);
                dcache_dout  = $urandom;
            end
        end
    end

    // ---------------- monitors / scoreboard ----------------
    initial begin
        logic [36:0] e;
        logic [31:0] last_csr;
        last_csr = RST_TOHOST;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_csr = csr_tohost;
                if (we) begin
                    checks++;
                    errors++;
                    $display("FAIL commit_in_reset: got we=1 expected 0");
                end
                continue;
            end
            if (we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit: got wa=%0d wd=%h expected no commit", wa, wd);
                end else begin
                    e = exp_q.pop_front();
                    check("commit", {wa, wd}, e);
                end
            end
            if (csr_tohost != last_csr) begin
                if (csr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_csr: got %h expected %h", csr_tohost, last_csr);
                end else begin
                    check("csr_tohost", csr_tohost, csr_q.pop_front());
                end
                last_csr = csr_tohost;
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        op_t op;
        drive('0);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i]   = $urandom;
            cache_mem[i] = ref_mem[i];
        end
        ref_mem[0]     = 32'h8044_2211;
        cache_mem[0]   = 32'h8044_2211;
        last_csr_model = RST_TOHOST;
        repeat (2) @(posedge clk);
        #1;
        check("reset_we", we, 1'b0);
        check("reset_stall_out", stall_out, 1'b0);
        check("reset_re", dcache_re, 1'b0);
        check("reset_dcache_we", dcache_we, 4'b0);
        check("reset_tohost", csr_tohost, RST_TOHOST);
        check("reset_state", dbg_state, 1'b0);
        rst = 1'b0;

        // LB of the top byte, then LHU of the upper half.
        op = '0; op.reg_we = 1; op.rr = 1; op.f3 = 3'd0; op.rd = 5'd5; op.alu = 32'h1003;
        issue(op, 1'b1);
        op = '0; op.reg_we = 1; op.rr = 1; op.f3 = 3'd5; op.rd = 5'd6; op.alu = 32'h1002;
        issue(op, 1'b1);
        op = '0; op.mw = 1; op.f3 = 3'd0; op.alu = 32'h2001; op.sd = 32'h0000_00AB;
        issue(op, 1'b1);
        // Three-cycle miss on a word load, followed immediately by another request.
        force_k = 3;
        op = '0; op.reg_we = 1; op.rr = 1; op.f3 = 3'd2; op.rd = 5'd7; op.alu = 32'h1000;
        issue(op, 1'b1);
        op = '0; op.reg_we = 1; op.rr = 1; op.f3 = 3'd1; op.rd = 5'd8; op.alu = 32'h1001;
        issue(op, 1'b1);
        op = '0; op.reg_we = 1; op.rd = 5'd0; op.alu = 32'h1234_5678;
        issue(op, 1'b1);
        op = '0; op.csr = 1; op.alu = 32'h1;
        issue(op, 1'b1);
        op = '0; op.bub = 1; op.reg_we = 1; op.rd = 5'd9; op.alu = 32'hDEAD;
        issue(op, 1'b1);
        nop();

        for (int n = 0; n < 300; n++) rand_op();
        drain();

        // Reset in the middle of a miss: the load must never commit.
        force_k = 3;
        op = '0; op.reg_we = 1; op.rr = 1; op.f3 = 3'd2; op.rd = 5'd10; op.alu = 32'h1010;
        issue(op, 1'b0);
        drive('{bub: 1'b1, default: '0});
        @(posedge clk);
        #3;
        check("wait_before_reset", dbg_state, 1'b1);
        rst = 1'b1;
        #1;
        check("abort_we", we, 1'b0);
        check("abort_stall_out", stall_out, 1'b0);
        check("abort_re", dcache_re, 1'b0);
        check("abort_dcache_we", dcache_we, 4'b0);
        check("abort_tohost", csr_tohost, RST_TOHOST);
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_csr_model = RST_TOHOST;
        repeat (4) nop();
        check("after_abort_state", dbg_state, 1'b0);
        check("after_abort_stall_out", stall_out, 1'b0);
        for (int n = 0; n < 30; n++) rand_op();
        drain();

        check("exp_q_empty", exp_q.size(), 0);
        check("req_q_empty", req_q.size(), 0);
        check("csr_q_empty", csr_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
